// File: rtl/uart_loader_pkg.sv
// Shared bus constants, ack codes and state type for the UART memory loader.
package uart_loader_pkg;

    localparam int unsigned BUS_WIDTH     = 32;
    localparam int unsigned BUS_ACC_WIDTH = 2;

    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'b10;

    localparam logic [7:0] ACK_OK      = 8'h00;
    localparam logic [7:0] ACK_CSUM    = 8'h01;
    localparam logic [7:0] ACK_FAULT   = 8'h02;
    localparam logic [7:0] ACK_OVERRUN = 8'h03;
    localparam logic [7:0] ACK_TIMEOUT = 8'h04;
    localparam logic [7:0] ACK_ALIGN   = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DRAIN,
        S_ACK
    } state_t;

endpackage

// File: rtl/uart_loader.sv
// Packet loader: parses sync/addr/len/payload/csum bytes from the UART RX
// stream, writes payload words to the bus and returns a one-byte ack.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = 8'h5A,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_vld,
    input  logic [7:0]               rx_data,
    input  logic                     tx_full,
    output logic                     tx_req,
    output logic [7:0]               tx_data,
    output logic [31:0]              addr,
    output logic                     w_rb,
    output logic [BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]     wdata,
    output logic                     req,
    input  logic                     resp,
    input  logic                     fault,
    output logic                     busy
);

    state_t      state, state_nxt;
    logic [31:0] base;
    logic [1:0]  byte_cnt;
    logic [8:0]  word_cnt;
    logic [7:0]  word_idx;
    logic [23:0] word_sr;
    logic [7:0]  csum;
    logic [7:0]  err;
    logic        pending;
    logic [31:0] tmo_cnt;

    logic        in_pkt, byte_in, timeout, bus_done, word_done, overrun, issue;
    logic [7:0]  csum_sum, err_pre, err_nxt;

    assign in_pkt    = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign byte_in   = rx_vld && in_pkt;
    assign timeout   = in_pkt && !rx_vld && (tmo_cnt == TIMEOUT_CYC - 1);
    assign bus_done  = pending && (resp || fault);
    assign word_done = byte_in && (state == S_DATA) && (byte_cnt == 2'd3);
    assign csum_sum  = csum + rx_data;

    // A fault retiring the outstanding write ranks ahead of anything decided by this cycle's byte.
    assign err_pre = (err == ACK_OK && pending && fault) ? ACK_FAULT : err;
    assign overrun = word_done && pending && !bus_done;
    assign issue   = word_done && (err_pre == ACK_OK) && !overrun;

    always_comb begin
        err_nxt = err_pre;
        if (err_pre == ACK_OK) begin
            if (overrun)
                err_nxt = ACK_OVERRUN;
            else if (byte_in && state == S_LEN && base[1:0] != 2'b00)
                err_nxt = ACK_ALIGN;
            else if (byte_in && state == S_CSUM && csum_sum != 8'h00)
                err_nxt = ACK_CSUM;
            else if (timeout)
                err_nxt = ACK_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_req    = 1'b0;
        tx_data   = '0;
        case (state)
            S_IDLE:  if (rx_vld && rx_data == SYNC_BYTE) state_nxt = S_ADDR;
            S_ADDR:  if (timeout) state_nxt = S_DRAIN;
                     else if (rx_vld && byte_cnt == 2'd3) state_nxt = S_LEN;
            S_LEN:   if (timeout) state_nxt = S_DRAIN;
                     else if (rx_vld) state_nxt = S_DATA;
            S_DATA:  if (timeout) state_nxt = S_DRAIN;
                     else if (word_done && word_cnt == 9'd1) state_nxt = S_CSUM;
            S_CSUM:  if (timeout || rx_vld) state_nxt = S_DRAIN;
            S_DRAIN: if (!pending) state_nxt = S_ACK;
            S_ACK:   if (!tx_full && !rst) begin
                         tx_req    = 1'b1;
                         tx_data   = err;
                         state_nxt = S_IDLE;
                     end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base     <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
            word_idx <= '0;
            word_sr  <= '0;
            csum     <= '0;
            err      <= ACK_OK;
            pending  <= 1'b0;
            tmo_cnt  <= '0;
            req      <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
        end else begin
            req     <= issue;
            err     <= err_nxt;
            tmo_cnt <= (in_pkt && !rx_vld) ? tmo_cnt + 32'd1 : '0;
            if (issue) begin
                addr  <= base + {22'd0, word_idx, 2'b00};
                wdata <= {rx_data, word_sr};
            end
            if (issue)
                pending <= 1'b1;
            else if (bus_done)
                pending <= 1'b0;

            if (state == S_IDLE && rx_vld && rx_data == SYNC_BYTE) begin
                base     <= '0;
                byte_cnt <= '0;
                word_cnt <= '0;
                word_idx <= '0;
                word_sr  <= '0;
                csum     <= '0;
                err      <= ACK_OK;
            end else if (byte_in) begin
                csum <= csum_sum;
                case (state)
                    S_ADDR: begin
                        base     <= {rx_data, base[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    S_LEN: begin
                        word_cnt <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        byte_cnt <= '0;
                        word_idx <= '0;
                    end
                    S_DATA: begin
                        word_sr  <= {rx_data, word_sr[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_cnt <= word_cnt - 9'd1;
                            word_idx <= word_idx + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_rb = 1'b1;
    assign acc  = BUS_ACC_4B;
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_loader.sv
// Directed and randomized packet bench for uart_loader with a bus responder
// and a packet-level reference model.
module tb_uart_loader;
    import uart_loader_pkg::*;

    localparam int unsigned TMO = 64;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     rx_vld = 1'b0;
    logic [7:0]               rx_data = 8'h00;
    logic                     tx_full = 1'b0;
    logic                     tx_req;
    logic [7:0]               tx_data;
    logic [31:0]              addr;
    logic                     w_rb;
    logic [BUS_ACC_WIDTH-1:0] acc;
    logic [BUS_WIDTH-1:0]     wdata;
    logic                     req;
    logic                     resp = 1'b0;
    logic                     fault = 1'b0;
    logic                     busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_loader #(.SYNC_BYTE(8'h5A), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_data(rx_data), .tx_full(tx_full),
        .tx_req(tx_req), .tx_data(tx_data), .addr(addr), .w_rb(w_rb), .acc(acc),
        .wdata(wdata), .req(req), .resp(resp), .fault(fault), .busy(busy)
    );

    // Bus responder: logs every request, answers after 'lat' cycles or faults on request 'fault_at'.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          lat = 2;
    int          fault_at = -1;
    int          countdown = 0;
    int          attr_bad = 0;
    int          hold_bad = 0;
    logic [31:0] held_addr, held_data;

    always begin
        @(posedge clk); #1;
        resp  = 1'b0;
        fault = 1'b0;
        if (rst) begin
            countdown = 0;
        end else if (req === 1'b1) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
            held_addr = addr;
            held_data = wdata;
            if (w_rb !== 1'b1 || acc !== BUS_ACC_4B) attr_bad++;
            if (wr_addr_q.size() - 1 == fault_at) fault = 1'b1;
            else countdown = lat;
        end else if (countdown > 0) begin
            if (addr !== held_addr || wdata !== held_data) hold_bad++;
            countdown--;
            if (countdown == 0) resp = 1'b1;
        end
    end

    logic [7:0] ack_q[$];
    always @(negedge clk) if (tx_req === 1'b1) ack_q.push_back(tx_data);

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    logic [7:0]  pkt[$];
    logic [31:0] words[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  exp_ack;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int g);
        rx_data = b;
        rx_vld  = 1'b1;
        tick();
        rx_vld  = 1'b0;
        for (int i = 1; i < g; i++) tick();
    endtask

    task automatic send_pkt(input int g);
        foreach (pkt[i]) send_byte(pkt[i], g);
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic build(input logic [31:0] a, input logic [7:0] len, input bit good);
        logic [7:0] sum;
        pkt.delete();
        pkt.push_back(8'h5A);
        for (int i = 0; i < 4; i++) pkt.push_back(a[8*i +: 8]);
        pkt.push_back(len);
        foreach (words[w]) for (int i = 0; i < 4; i++) pkt.push_back(words[w][8*i +: 8]);
        sum = 8'h00;
        for (int i = 1; i < pkt.size(); i++) sum += pkt[i];
        pkt.push_back(good ? 8'(8'h00 - sum) : 8'(8'h01 - sum));
    endtask

    // Packet-level model: word k completes 4*g*k cycles after word 0; a write is busy until 1+l cycles later.
    task automatic model(input int g, input int l, input int fidx);
        logic [31:0] a;
        logic [7:0]  sum, e;
        int          nw, resp_cyc, issued, t;
        exp_addr.delete();
        exp_data.delete();
        a   = {pkt[4], pkt[3], pkt[2], pkt[1]};
        nw  = (pkt[5] == 8'h00) ? 256 : int'(pkt[5]);
        sum = 8'h00;
        for (int i = 1; i < pkt.size(); i++) sum += pkt[i];
        e = (a[1:0] != 2'b00) ? 8'h05 : 8'h00;
        resp_cyc = 0;
        issued   = 0;
        for (int k = 0; k < nw; k++) begin
            t = k * 4 * g;
            if (e == 8'h00) begin
                if (issued > 0 && t < resp_cyc) begin
                    e = 8'h03;
                end else begin
                    exp_addr.push_back(a + 32'(4 * k));
                    exp_data.push_back({pkt[9+4*k], pkt[8+4*k], pkt[7+4*k], pkt[6+4*k]});
                    if (issued == fidx) e = 8'h02;
                    else resp_cyc = t + 1 + l;
                    issued++;
                end
            end
        end
        if (e == 8'h00 && sum != 8'h00) e = 8'h01;
        exp_ack = e;
    endtask

    task automatic wait_ack(input int ab, input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            tick();
            got = (ack_q.size() > ab);
        end
    endtask

    task automatic finish_pkt(input string tag, input int wb, input int ab, input int max_cyc);
        bit got;
        wait_ack(ab, max_cyc, got);
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        if (got) chk({tag, "_ack"}, ack_q[ab], exp_ack);
        chk({tag, "_nwrites"}, wr_addr_q.size() - wb, exp_addr.size());
        for (int i = 0; i < exp_addr.size() && wb + i < wr_addr_q.size(); i++) begin
            chk({tag, "_waddr"}, wr_addr_q[wb+i], exp_addr[i]);
            chk({tag, "_wdata"}, wr_data_q[wb+i], exp_data[i]);
        end
        tick();
        chk({tag, "_nacks"}, ack_q.size() - ab, 32'd1);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_bus_attr"}, attr_bad, 32'd0);
        chk({tag, "_bus_hold"}, hold_bad, 32'd0);
    endtask

    task automatic run_pkt(input string tag, input int g, input int l, input int fidx);
        int wb, ab;
        wb = wr_addr_q.size();
        ab = ack_q.size();
        lat = l;
        fault_at = (fidx < 0) ? -1 : wb + fidx;
        model(g, l, fidx);
        send_pkt(g);
        finish_pkt(tag, wb, ab, 100);
        fault_at = -1;
    endtask

    initial begin
        int wb, ab, len, g, l, fidx;
        logic [31:0] a;
        bit good;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", req, 1'b0);
        chk("rst_tx_req", tx_req, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_w_rb", w_rb, 1'b1);
        chk("rst_acc", acc, BUS_ACC_4B);
        rst = 1'b0;
        tick();

        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        chk("junk_ignored", busy, 1'b0);

        words.delete();
        words.push_back(32'hDEADBEEF);
        build(32'h0000_1000, 8'd1, 1'b1);
        run_pkt("good", 1, 2, -1);

        build(32'h0000_1000, 8'd1, 1'b0);
        run_pkt("badcsum", 1, 2, -1);

        fill_words(2);
        build(32'h0000_2000, 8'd2, 1'b1);
        run_pkt("fault", 1, 2, 0);

        fill_words(1);
        build(32'h0000_0002, 8'd1, 1'b1);
        run_pkt("align", 1, 2, -1);

        fill_words(3);
        build(32'h0000_4000, 8'd3, 1'b1);
        run_pkt("overrun", 1, 8, -1);

        fill_words(1);
        build(32'h0000_3000, 8'd1, 1'b1);
        wb = wr_addr_q.size();
        ab = ack_q.size();
        for (int i = 0; i < 6; i++) send_byte(pkt[i], 1);
        repeat (TMO - 8) tick();
        chk("tmo_no_early_ack", ack_q.size() - ab, 32'd0);
        chk("tmo_busy_in_gap", busy, 1'b1);
        exp_addr.delete();
        exp_data.delete();
        exp_ack = 8'h04;
        finish_pkt("tmo", wb, ab, 40);

        fill_words(2);
        build(32'h0000_5000, 8'd2, 1'b1);
        wb = wr_addr_q.size();
        ab = ack_q.size();
        lat = 2;
        model(1, 2, -1);
        tx_full = 1'b1;
        send_pkt(1);
        repeat (50) tick();
        chk("txfull_held_ack", ack_q.size() - ab, 32'd0);
        chk("txfull_busy", busy, 1'b1);
        chk("txfull_no_tx_req", tx_req, 1'b0);
        tx_full = 1'b0;
        finish_pkt("txfull", wb, ab, 3);

        fill_words(2);
        build(32'h0000_0100, 8'd2, 1'b1);
        wb = wr_addr_q.size();
        ab = ack_q.size();
        for (int i = 0; i < 8; i++) send_byte(pkt[i], 1);
        rst = 1'b1;
        tick();
        tick();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_req", req, 1'b0);
        rst = 1'b0;
        repeat (20) tick();
        chk("midrst_no_write", wr_addr_q.size() - wb, 32'd0);
        chk("midrst_no_ack", ack_q.size() - ab, 32'd0);
        fill_words(2);
        build(32'h0000_0200, 8'd2, 1'b1);
        run_pkt("after_rst", 1, 2, -1);

        for (int r = 0; r < 24; r++) begin
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            good = ($urandom_range(0, 3) != 0);
            if (r == 5) begin
                len = 0;
                g = 1;
                l = $urandom_range(1, 3);
                fidx = -1;
                fill_words(256);
            end else begin
                len = $urandom_range(1, 6);
                g = $urandom_range(1, 3);
                l = $urandom_range(1, 12);
                fidx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len - 1) : -1;
                fill_words(len);
            end
            build(a, 8'(len), good);
            run_pkt("rand", g, l, fidx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
